// File: rtl/encoder_position_counter_pkg.sv
// Shared motion definitions: default widths, index-mode encoding and velocity FSM states.
package encoder_position_counter_pkg;

    localparam int DEF_POS_WIDTH = 32;
    localparam int DEF_VEL_WIDTH = 16;
    localparam int DEF_PER_WIDTH = 16;

    typedef enum logic [1:0] {
        IDX_IGNORE       = 2'd0,
        IDX_CAPTURE      = 2'd1,
        IDX_ZERO         = 2'd2,
        IDX_CAPTURE_ZERO = 2'd3
    } index_mode_e;

    typedef enum logic {
        VEL_IDLE = 1'b0,
        VEL_RUN  = 1'b1
    } vel_state_e;

    function automatic logic mode_captures(input logic [1:0] mode);
        return (mode == IDX_CAPTURE) || (mode == IDX_CAPTURE_ZERO);
    endfunction

    function automatic logic mode_zeroes(input logic [1:0] mode);
        return (mode == IDX_ZERO) || (mode == IDX_CAPTURE_ZERO);
    endfunction

endpackage

// File: rtl/encoder_position_counter_if.sv
// Encoder counter bus: decoded count/index controls in, position and velocity results out.
interface encoder_position_counter_if
    import encoder_position_counter_pkg::*;
#(
    parameter int POS_WIDTH = DEF_POS_WIDTH,
    parameter int VEL_WIDTH = DEF_VEL_WIDTH,
    parameter int PER_WIDTH = DEF_PER_WIDTH
);
    logic                 count_pulse;
    logic                 direction;
    logic                 index;
    logic                 clear_pos;
    logic [1:0]           index_mode;
    logic [PER_WIDTH-1:0] period;
    logic [POS_WIDTH-1:0] position;
    logic [POS_WIDTH-1:0] index_position;
    logic                 index_seen;
    logic [VEL_WIDTH-1:0] velocity;
    logic                 velocity_valid;
    logic                 vel_sat;

    modport master (
        output count_pulse, direction, index, clear_pos, index_mode, period,
        input  position, index_position, index_seen, velocity, velocity_valid, vel_sat
    );

    modport slave (
        input  count_pulse, direction, index, clear_pos, index_mode, period,
        output position, index_position, index_seen, velocity, velocity_valid, vel_sat
    );
endinterface

// File: rtl/encoder_position_counter_velocity_window.sv
// Counts signed encoder pulses over windows of exactly `period` cycles and reports a saturated rate.
module velocity_window
    import encoder_position_counter_pkg::*;
#(
    parameter int PER_WIDTH = DEF_PER_WIDTH,
    parameter int VEL_WIDTH = DEF_VEL_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 count_pulse_i,
    input  logic                 direction_i,
    input  logic [PER_WIDTH-1:0] period_i,
    output logic [VEL_WIDTH-1:0] velocity_o,
    output logic                 velocity_valid_o,
    output logic                 vel_sat_o
);
    localparam logic [0:0] ST_IDLE = VEL_IDLE;
    localparam logic [0:0] ST_RUN  = VEL_RUN;
    // Wide enough that a full window of same-direction pulses can never wrap.
    localparam int SUM_W = (PER_WIDTH + 2 > VEL_WIDTH + 1) ? PER_WIDTH + 2 : VEL_WIDTH + 1;
    localparam logic signed [SUM_W-1:0] VEL_MAX = SUM_W'((64'sd1 <<< (VEL_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] VEL_MIN = -VEL_MAX;

    logic [0:0]              state_q, state_d;
    logic [PER_WIDTH-1:0]    cnt_q, cnt_d;
    logic signed [SUM_W-1:0] acc_q, acc_d;
    logic signed [SUM_W-1:0] step, sum;
    logic [VEL_WIDTH-1:0]    velocity_q, velocity_d;
    logic                    valid_q, valid_d;
    logic                    sat_q, sat_d;

    always_comb begin
        step = '0;
        if (count_pulse_i) step = direction_i ? SUM_W'(1) : {SUM_W{1'b1}};
        sum        = acc_q + step;
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        velocity_d = velocity_q;
        valid_d    = 1'b0;
        sat_d      = sat_q;
        if (period_i == '0) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            acc_d      = '0;
            velocity_d = '0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
            cnt_d   = period_i - PER_WIDTH'(1);
            acc_d   = '0;
        end else if (cnt_q == '0) begin
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = period_i - PER_WIDTH'(1);
            if (sum > VEL_MAX) begin
                velocity_d = VEL_MAX[VEL_WIDTH-1:0];
                sat_d      = 1'b1;
            end else if (sum < VEL_MIN) begin
                velocity_d = VEL_MIN[VEL_WIDTH-1:0];
                sat_d      = 1'b1;
            end else begin
                velocity_d = sum[VEL_WIDTH-1:0];
            end
        end else begin
            cnt_d = cnt_q - PER_WIDTH'(1);
            acc_d = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            velocity_q <= '0;
            valid_q    <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            velocity_q <= velocity_d;
            valid_q    <= valid_d;
            sat_q      <= sat_d;
        end
    end

    assign velocity_o       = velocity_q;
    assign velocity_valid_o = valid_q;
    assign vel_sat_o        = sat_q;
endmodule

// File: rtl/encoder_position_counter.sv
// Quadrature position counter with index capture/zeroing and a windowed velocity estimate.
module encoder_position_counter
    import encoder_position_counter_pkg::*;
#(
    parameter int POS_WIDTH = DEF_POS_WIDTH,
    parameter int VEL_WIDTH = DEF_VEL_WIDTH,
    parameter int PER_WIDTH = DEF_PER_WIDTH
) (
    input logic                   clk,
    input logic                   reset,
    encoder_position_counter_if.slave bus
);
    logic [POS_WIDTH-1:0] position_q, position_d;
    logic [POS_WIDTH-1:0] index_position_q, index_position_d;
    logic                 index_seen_q, index_seen_d;
    logic                 index_prev_q;
    logic                 index_edge;
    logic [VEL_WIDTH-1:0] velocity_w;
    logic                 velocity_valid_w;
    logic                 vel_sat_w;

    always_comb begin
        index_edge       = bus.index & ~index_prev_q;
        position_d       = position_q;
        index_position_d = index_position_q;
        index_seen_d     = index_seen_q;
        // A clear or index zero wins over, and swallows, a same-cycle count pulse.
        if (bus.clear_pos) begin
            position_d = '0;
        end else if (index_edge && mode_zeroes(bus.index_mode)) begin
            position_d = '0;
        end else if (bus.count_pulse) begin
            position_d = bus.direction ? position_q + POS_WIDTH'(1) : position_q - POS_WIDTH'(1);
        end
        if (index_edge && mode_captures(bus.index_mode)) begin
            index_position_d = position_q;
            index_seen_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            position_q       <= '0;
            index_position_q <= '0;
            index_seen_q     <= 1'b0;
            index_prev_q     <= 1'b0;
        end else begin
            position_q       <= position_d;
            index_position_q <= index_position_d;
            index_seen_q     <= index_seen_d;
            index_prev_q     <= bus.index;
        end
    end

    velocity_window #(
        .PER_WIDTH(PER_WIDTH),
        .VEL_WIDTH(VEL_WIDTH)
    ) u_velocity_window (
        .clk             (clk),
        .reset           (reset),
        .count_pulse_i   (bus.count_pulse),
        .direction_i     (bus.direction),
        .period_i        (bus.period),
        .velocity_o      (velocity_w),
        .velocity_valid_o(velocity_valid_w),
        .vel_sat_o       (vel_sat_w)
    );

    assign bus.position       = position_q;
    assign bus.index_position = index_position_q;
    assign bus.index_seen     = index_seen_q;
    assign bus.velocity       = velocity_w;
    assign bus.velocity_valid = velocity_valid_w;
    assign bus.vel_sat        = vel_sat_w;
endmodule
